adc_seq: RTL and testbench

ADC_SEQ -- requirements
Module: adc_seq

---
 rtl/adc_seq.sv | 175 +++++++++++++++++
 tb/tb_adc_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq.sv
// Round-robin ADC sequencer: arbitrates four request channels onto one ADC,
// drives per-channel configuration, and hands back results with a timeout path.
module adc_seq #(
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_in,
    output logic [3:0]  grant_out,
    input  logic        cfg_wr_en,
    input  logic [2:0]  cfg_wr_addr,
    input  logic [15:0] cfg_wr_data,
    output logic [15:0] adc_config_1_out,
    output logic [15:0] adc_config_2_out,
    output logic        adc_start_out,
    input  logic        adc_finished_in,
    input  logic [15:0] adc_result_in,
    output logic        res_valid_out,
    output logic [1:0]  res_ch_out,
    output logic [15:0] res_data_out,
    output logic        res_timeout_out,
    input  logic        res_ack_in,
    output logic        busy_out,
    output logic        timeout_err_out,
    input  logic        err_clr_in
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CW-1:0] SETUP_LAST   = CW'((SETUP_CYCLES == 0) ? 0 : SETUP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT,
        DELIVER
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    rr;
    logic [1:0]    grant_ch;
    logic [15:0]   cfg1_q [4];
    logic [15:0]   cfg2_q [4];
    logic [2:0]    fin_sync;
    logic          fin_rise;
    logic          pick_valid;
    logic [1:0]    pick_ch;
    logic [1:0]    cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cfg1_q[i] <= '0;
                cfg2_q[i] <= '0;
            end
        end else if (cfg_wr_en) begin
            if (cfg_wr_addr[2])
                cfg2_q[cfg_wr_addr[1:0]] <= cfg_wr_data;
            else
                cfg1_q[cfg_wr_addr[1:0]] <= cfg_wr_data;
        end
    end

    // Two synchronizer stages plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fin_sync <= '0;
        else
            fin_sync <= {fin_sync[1:0], adc_finished_in};
    end

    assign fin_rise = fin_sync[1] & ~fin_sync[2];

    always_comb begin
        pick_valid = 1'b0;
        pick_ch    = '0;
        cand       = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = rr + 2'(i);
            if (!pick_valid && req_in[cand]) begin
                pick_valid = 1'b1;
                pick_ch    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            rr               <= '0;
            grant_ch         <= '0;
            grant_out        <= '0;
            adc_config_1_out <= '0;
            adc_config_2_out <= '0;
            adc_start_out    <= 1'b0;
            res_valid_out    <= 1'b0;
            res_ch_out       <= '0;
            res_data_out     <= '0;
            res_timeout_out  <= 1'b0;
            busy_out         <= 1'b0;
            timeout_err_out  <= 1'b0;
        end else begin
            adc_start_out <= 1'b0;
            if (err_clr_in)
                timeout_err_out <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_ch         <= pick_ch;
                        grant_out        <= 4'b0001 << pick_ch;
                        adc_config_1_out <= cfg1_q[pick_ch];
                        adc_config_2_out <= cfg2_q[pick_ch];
                        busy_out         <= 1'b1;
                        if (SETUP_CYCLES == 0) begin
                            state         <= START;
                            adc_start_out <= 1'b1;
                        end else begin
                            state <= SETUP;
                            cnt   <= SETUP_LAST;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state         <= START;
                        adc_start_out <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                // Edges are only honoured here, so a level left high from
                // before the start pulse never completes a conversion.
                WAIT: begin
                    if (fin_rise) begin
                        res_data_out    <= adc_result_in;
                        res_timeout_out <= 1'b0;
                        res_valid_out   <= 1'b1;
                        res_ch_out      <= grant_ch;
                        state           <= DELIVER;
                    end else if (cnt == TIMEOUT_LAST) begin
                        res_data_out    <= 16'hFFFF;
                        res_timeout_out <= 1'b1;
                        res_valid_out   <= 1'b1;
                        res_ch_out      <= grant_ch;
                        timeout_err_out <= 1'b1;
                        state           <= DELIVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DELIVER: begin
                    if (res_ack_in) begin
                        res_valid_out <= 1'b0;
                        grant_out     <= '0;
                        busy_out      <= 1'b0;
                        rr            <= grant_ch + 2'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_seq.sv
// Self-checking bench for adc_seq: table-driven arbitration vectors plus
// hand-written timeout, stale-edge, backpressure and reset sequences.
module tb_adc_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_in;
    logic [3:0]  grant_out;
    logic        cfg_wr_en;
    logic [2:0]  cfg_wr_addr;
    logic [15:0] cfg_wr_data;
    logic [15:0] adc_config_1_out;
    logic [15:0] adc_config_2_out;
    logic        adc_start_out;
    logic        adc_finished_in;
    logic [15:0] adc_result_in;
    logic        res_valid_out;
    logic [1:0]  res_ch_out;
    logic [15:0] res_data_out;
    logic        res_timeout_out;
    logic        res_ack_in;
    logic        busy_out;
    logic        timeout_err_out;
    logic        err_clr_in;

    adc_seq #(
        .SETUP_CYCLES  (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_in          (req_in),
        .grant_out       (grant_out),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_wr_addr     (cfg_wr_addr),
        .cfg_wr_data     (cfg_wr_data),
        .adc_config_1_out(adc_config_1_out),
        .adc_config_2_out(adc_config_2_out),
        .adc_start_out   (adc_start_out),
        .adc_finished_in (adc_finished_in),
        .adc_result_in   (adc_result_in),
        .res_valid_out   (res_valid_out),
        .res_ch_out      (res_ch_out),
        .res_data_out    (res_data_out),
        .res_timeout_out (res_timeout_out),
        .res_ack_in      (res_ack_in),
        .busy_out        (busy_out),
        .timeout_err_out (timeout_err_out),
        .err_clr_in      (err_clr_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] data;
        logic        tmo;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] result;
        logic [1:0]  exp_ch;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[9];
    logic [15:0] m_cfg1[4];
    logic [15:0] m_cfg2[4];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = addr;
        cfg_wr_data = data;
        tick();
        cfg_wr_en = 1'b0;
        if (addr[2]) m_cfg2[addr[1:0]] = data;
        else         m_cfg1[addr[1:0]] = data;
    endtask

    // Raise a request from IDLE and follow it to the start pulse.
    task automatic start_conv(input logic [3:0] req, input logic [1:0] ch);
        int n = 0;
        req_in = req;
        while (adc_start_out !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("start_latency", n, 3);
        chk("grant", grant_out, 32'(4'b0001 << ch));
        chk("busy", busy_out, 1);
        chk("cfg1_out", adc_config_1_out, m_cfg1[ch]);
        chk("cfg2_out", adc_config_2_out, m_cfg2[ch]);
        tick();
        chk("start_width", adc_start_out, 0);
    endtask

    task automatic wait_result(output int n);
        exp_t e;
        n = 0;
        while (res_valid_out !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("valid_seen", res_valid_out, 1);
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("res_ch", res_ch_out, e.ch);
            chk("res_data", res_data_out, e.data);
            chk("res_timeout", res_timeout_out, e.tmo);
        end
    endtask

    task automatic finish_conv(input logic [15:0] result, input logic [1:0] ch);
        int n;
        adc_result_in   = result;
        adc_finished_in = 1'b1;
        sb.push_back('{ch, result, 1'b0});
        wait_result(n);
    endtask

    task automatic ack_conv;
        res_ack_in = 1'b1;
        tick();
        res_ack_in = 1'b0;
        chk("valid_after_ack", res_valid_out, 0);
        chk("grant_after_ack", grant_out, 0);
        chk("busy_after_ack", busy_out, 0);
        adc_finished_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [15:0] old;
        logic        seen;

        rst_n = 1'b0; req_in = '0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        adc_finished_in = 1'b0; adc_result_in = '0; res_ack_in = 1'b0; err_clr_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_cfg1[i] = '0;
            m_cfg2[i] = '0;
        end

        vecs[0] = '{4'b1111, 16'h0A00, 2'd0};
        vecs[1] = '{4'b1111, 16'h0A01, 2'd1};
        vecs[2] = '{4'b1111, 16'h0A02, 2'd2};
        vecs[3] = '{4'b1111, 16'h0A03, 2'd3};
        vecs[4] = '{4'b1111, 16'h0A04, 2'd0};
        vecs[5] = '{4'b0001, 16'h0A05, 2'd0};
        vecs[6] = '{4'b1001, 16'h0A06, 2'd3};
        vecs[7] = '{4'b1010, 16'h0A07, 2'd1};
        vecs[8] = '{4'b0011, 16'h0A08, 2'd0};

        tick(); tick();
        chk("rst_grant", grant_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_start", adc_start_out, 0);
        chk("rst_valid", res_valid_out, 0);
        chk("rst_data", res_data_out, 0);
        chk("rst_cfg1", adc_config_1_out, 0);
        chk("rst_err", timeout_err_out, 0);
        rst_n = 1'b1;
        tick();

        cfg_write(3'b000, 16'h1111);
        cfg_write(3'b111, 16'h3333);

        // Round-robin arbitration table
        for (int i = 0; i < 9; i++) begin
            start_conv(vecs[i].req, vecs[i].exp_ch);
            finish_conv(vecs[i].result, vecs[i].exp_ch);
            ack_conv();
        end
        req_in = '0;

        // Single request on channel 2
        cfg_write(3'b010, 16'h0400);
        cfg_write(3'b110, 16'h8421);
        start_conv(4'b0100, 2'd2);
        finish_conv(16'h1234, 2'd2);
        ack_conv();
        req_in = '0;

        // Request dropped after grant still completes
        start_conv(4'b0010, 2'd1);
        req_in = '0;
        finish_conv(16'h5555, 2'd1);
        ack_conv();

        // Ack held throughout: ignored until DELIVER, then completes in first cycle
        res_ack_in = 1'b1;
        start_conv(4'b0001, 2'd0);
        req_in = '0;
        finish_conv(16'h7777, 2'd0);
        tick();
        chk("ack_first_cycle", res_valid_out, 0);
        res_ack_in = 1'b0;
        adc_finished_in = 1'b0;

        // Backpressure plus mid-conversion config write
        start_conv(4'b0010, 2'd1);
        old = m_cfg1[1];
        cfg_write(3'b001, 16'hBEEF);
        chk("cfg_hold_midconv", adc_config_1_out, old);
        finish_conv(16'h2468, 2'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", res_valid_out, 1);
            chk("bp_data", res_data_out, 16'h2468);
            chk("bp_start", adc_start_out, 0);
        end
        ack_conv();
        req_in = '0;
        start_conv(4'b0010, 2'd1);
        finish_conv(16'h1357, 2'd1);
        ack_conv();
        req_in = '0;

        // Timeout
        start_conv(4'b0100, 2'd2);
        req_in = '0;
        sb.push_back('{2'd2, 16'hFFFF, 1'b1});
        wait_result(n);
        chk("timeout_cycles", n, 16);
        chk("timeout_err_set", timeout_err_out, 1);
        ack_conv();
        tick(); tick(); tick();
        chk("timeout_err_sticky", timeout_err_out, 1);
        err_clr_in = 1'b1;
        tick();
        err_clr_in = 1'b0;
        chk("timeout_err_clr", timeout_err_out, 0);

        // Clear held across a new timeout: set wins
        err_clr_in = 1'b1;
        start_conv(4'b1000, 2'd3);
        req_in = '0;
        sb.push_back('{2'd3, 16'hFFFF, 1'b1});
        wait_result(n);
        chk("err_set_over_clr", timeout_err_out, 1);
        err_clr_in = 1'b0;
        tick();
        chk("err_after_clr_release", timeout_err_out, 1);
        ack_conv();
        err_clr_in = 1'b1;
        tick();
        err_clr_in = 1'b0;

        // Stale finished level
        adc_finished_in = 1'b1;
        tick(); tick(); tick();
        start_conv(4'b0001, 2'd0);
        req_in = '0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (res_valid_out) seen = 1'b1;
        end
        adc_finished_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (res_valid_out) seen = 1'b1;
        end
        chk("stale_no_complete", seen, 0);
        finish_conv(16'hABCD, 2'd0);
        ack_conv();

        // Reset during WAIT
        start_conv(4'b0100, 2'd2);
        req_in = '0;
        adc_finished_in = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", grant_out, 0);
        chk("arst_busy", busy_out, 0);
        chk("arst_cfg1", adc_config_1_out, 0);
        chk("arst_cfg2", adc_config_2_out, 0);
        chk("arst_ch", res_ch_out, 0);
        for (int i = 0; i < 4; i++) begin
            m_cfg1[i] = '0;
            m_cfg2[i] = '0;
        end
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid_out || busy_out) seen = 1'b1;
        end
        chk("no_result_after_reset", seen, 0);
        start_conv(4'b1010, 2'd1);
        finish_conv(16'h4242, 2'd1);
        ack_conv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
